// File: rtl/hit_judge.sv
// Per-arrow hit/miss judge: debounces four lane keys, scores them against the arrow in the hit zone.
// Optional: define STRAY_PENALTY_EN to emit DOWN on presses outside an open window.
module hit_judge #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DB_W      = 3
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] KEY,
    input  logic [3:0] ARROW,
    output logic       UP,
    output logic       DOWN,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        JUDGED = 2'd2
    } state_t;

    localparam logic [DB_W-1:0] LP_DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [3:0]      r_s1;
    logic [3:0]      r_s2;
    logic [3:0]      r_filt;
    logic [3:0]      r_filt_q;
    logic [DB_W-1:0] r_cnt [4];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_tgt;
    logic [3:0]      r_got;
    logic [3:0]      w_tgt_nxt;
    logic [3:0]      w_got_nxt;
    logic            r_up;
    logic            r_down;
    logic            w_up_nxt;
    logic            w_down_nxt;

    logic [3:0]      w_press;
    logic            w_wrong;
    logic            w_complete;
    logic            w_arrow_new;
    logic            w_stray;

    // Key path: synchronizer, per-lane debounce counter, rising-edge detect
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_filt   <= '0;
            r_filt_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1     <= KEY;
            r_s2     <= r_s1;
            r_filt_q <= r_filt;
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_DB_LAST) begin
                    r_filt[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_press     = r_filt & ~r_filt_q;
    assign w_wrong     = |(w_press & ~r_tgt);
    assign w_complete  = !w_wrong && ((r_got | w_press) == r_tgt);
    assign w_arrow_new = (ARROW != 4'd0) && (ARROW != r_tgt);

`ifdef STRAY_PENALTY_EN
    assign w_stray = (r_state != WINDOW) && (w_press != 4'd0);
`else
    assign w_stray = 1'b0;
`endif

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_tgt   <= '0;
            r_got   <= '0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_got   <= w_got_nxt;
            r_up    <= w_up_nxt;
            r_down  <= w_down_nxt;
        end
    end

    // Next-state logic; a completing hit follows the same ARROW rules as JUDGED
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_got_nxt   = r_got;
        case (r_state)
            IDLE: begin
                if (ARROW != 4'd0) begin
                    w_tgt_nxt   = ARROW;
                    w_got_nxt   = '0;
                    w_state_nxt = WINDOW;
                end
            end
            WINDOW: begin
                if (w_wrong) begin
                    w_state_nxt = JUDGED;
                end else if (w_complete) begin
                    w_got_nxt = r_got | w_press;
                    if (ARROW == 4'd0) begin
                        w_state_nxt = IDLE;
                    end else if (w_arrow_new) begin
                        w_tgt_nxt   = ARROW;
                        w_got_nxt   = '0;
                        w_state_nxt = WINDOW;
                    end else begin
                        w_state_nxt = JUDGED;
                    end
                end else begin
                    w_got_nxt = r_got | w_press;
                    if (ARROW == 4'd0) begin
                        w_state_nxt = IDLE;
                    end else if (w_arrow_new) begin
                        w_tgt_nxt = ARROW;
                        w_got_nxt = '0;
                    end
                end
            end
            JUDGED: begin
                if (ARROW == 4'd0) begin
                    w_state_nxt = IDLE;
                end else if (w_arrow_new) begin
                    w_tgt_nxt   = ARROW;
                    w_got_nxt   = '0;
                    w_state_nxt = WINDOW;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output logic; pulses are registered one edge later
    always_comb begin
        w_up_nxt   = 1'b0;
        w_down_nxt = 1'b0;
        if (r_state == WINDOW) begin
            w_up_nxt   = w_complete;
            w_down_nxt = w_wrong || (!w_complete && (ARROW != r_tgt));
        end else begin
            w_down_nxt = w_stray;
        end
    end

    assign UP   = r_up;
    assign DOWN = r_down;
    assign BUSY = (r_state == WINDOW);

endmodule
